// File: rtl/pulse_count_ctrl.sv
// Multi-channel gated pulse counter: synchronises pulses, counts rising edges over gapless
// windows and publishes per-window totals. Optional build macro: PULSE_CNT_SATURATE_EN.
module pulse_count_ctrl #(
    parameter int unsigned CH          = 2,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned GATE_CYCLES = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                SYS_CLK,
    input  logic                S_RESET_N,
    input  logic [CH-1:0]       PULSE,
    input  logic                ENABLE,
    output logic [CH-1:0]       INC,
    output logic                SCLR,
    output logic                LOAD,
    output logic [CH*CNT_W-1:0] COUNT_OUT,
    output logic                VALID,
    output logic [CH-1:0]       OVF
);

    localparam int unsigned TW = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [TW-1:0]    TIMER_LAST = TW'(GATE_CYCLES - 2);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    typedef enum logic [1:0] {StIdle, StCount, StLoad} state_e;

    logic [SYNC_STAGES-1:0][CH-1:0] r_sync;
    logic [CH-1:0]                  r_prev;
    logic [CH-1:0]                  r_inc;

    state_e                         r_state;
    logic [TW-1:0]                  r_timer;
    logic [CH-1:0][CNT_W-1:0]       r_cnt;
    logic [CH-1:0]                  r_ovf_pend;
    logic                           r_sclr;
    logic                           r_load;
    logic                           r_valid;
    logic [CH-1:0][CNT_W-1:0]       r_count_out;
    logic [CH-1:0]                  r_ovf;

    logic [CH-1:0][CNT_W-1:0]       w_cnt_nxt;
    logic [CH-1:0]                  w_hit;

    always_ff @(posedge SYS_CLK) begin
        if (!S_RESET_N) begin
            r_sync <= '0;
            r_prev <= '0;
            r_inc  <= '0;
        end else begin
            r_sync[0] <= PULSE;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_prev <= r_sync[SYNC_STAGES-1];
            r_inc  <= r_sync[SYNC_STAGES-1] & ~r_prev;
        end
    end

    // An edge arriving while a counter is already at max marks the window as overflowed.
    always_comb begin
        w_hit     = '0;
        w_cnt_nxt = r_cnt;
        for (int k = 0; k < int'(CH); k++) begin
            w_hit[k] = r_inc[k] && (r_cnt[k] == CNT_MAX);
`ifdef PULSE_CNT_SATURATE_EN
            w_cnt_nxt[k] = w_hit[k] ? r_cnt[k] : r_cnt[k] + CNT_W'(r_inc[k]);
`else
            w_cnt_nxt[k] = r_cnt[k] + CNT_W'(r_inc[k]);
`endif
        end
    end

    always_ff @(posedge SYS_CLK) begin
        if (!S_RESET_N) begin
            r_state     <= StIdle;
            r_timer     <= '0;
            r_cnt       <= '0;
            r_ovf_pend  <= '0;
            r_sclr      <= 1'b0;
            r_load      <= 1'b0;
            r_valid     <= 1'b0;
            r_count_out <= '0;
            r_ovf       <= '0;
        end else begin
            r_sclr <= 1'b0;
            r_load <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (ENABLE) begin
                        r_state    <= StCount;
                        r_sclr     <= 1'b1;
                        r_timer    <= '0;
                        r_cnt      <= '0;
                        r_ovf_pend <= '0;
                    end
                end
                StCount: begin
                    r_cnt      <= w_cnt_nxt;
                    r_ovf_pend <= r_ovf_pend | w_hit;
                    r_timer    <= r_timer + TW'(1);
                    if (r_timer == TIMER_LAST) begin
                        r_state <= StLoad;
                        r_load  <= 1'b1;
                        r_sclr  <= 1'b1;
                    end
                end
                StLoad: begin
                    // Totals include this cycle's edges so nothing is lost at the boundary.
                    r_count_out <= w_cnt_nxt;
                    r_ovf       <= r_ovf_pend | w_hit;
                    r_valid     <= 1'b1;
                    r_cnt       <= '0;
                    r_ovf_pend  <= '0;
                    r_timer     <= '0;
                    r_state     <= ENABLE ? StCount : StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign INC       = r_inc;
    assign SCLR      = r_sclr;
    assign LOAD      = r_load;
    assign COUNT_OUT = r_count_out;
    assign VALID     = r_valid;
    assign OVF       = r_ovf;

endmodule

// File: tb/tb_pulse_count_ctrl.sv
// Self-checking bench for pulse_count_ctrl: scoreboard of window totals popped on each LOAD.
// A second instance with a longer window exercises counter overflow.
module tb_pulse_count_ctrl;

    typedef struct packed {
        logic [7:0] cnt;
        logic [1:0] ovf;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] pulse, pulse_l;
    logic       en, en_l;

    logic [1:0] inc, inc_l;
    logic       sclr, sclr_l, load, load_l, valid, valid_l;
    logic [7:0] cnt_out, cnt_out_l;
    logic [1:0] ovf, ovf_l;

    exp_t q_main[$];
    exp_t q_long[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #50 clk = ~clk;

    pulse_count_ctrl #(.CH(2), .CNT_W(4), .GATE_CYCLES(16), .SYNC_STAGES(2)) u_dut (
        .SYS_CLK(clk), .S_RESET_N(rst_n), .PULSE(pulse), .ENABLE(en),
        .INC(inc), .SCLR(sclr), .LOAD(load), .COUNT_OUT(cnt_out), .VALID(valid), .OVF(ovf)
    );

    pulse_count_ctrl #(.CH(2), .CNT_W(4), .GATE_CYCLES(48), .SYNC_STAGES(2)) u_dut_long (
        .SYS_CLK(clk), .S_RESET_N(rst_n), .PULSE(pulse_l), .ENABLE(en_l),
        .INC(inc_l), .SCLR(sclr_l), .LOAD(load_l), .COUNT_OUT(cnt_out_l), .VALID(valid_l),
        .OVF(ovf_l)
    );

    // Scoreboard monitors: results appear the cycle after LOAD.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (load === 1'b1) begin
                @(negedge clk);
                n_cmp++;
                if (q_main.size() == 0) begin
                    n_err++;
                    $display("FAIL main_unexpected_load: LOAD seen with no expected window");
                end else begin
                    e = q_main.pop_front();
                    if (cnt_out !== e.cnt || ovf !== e.ovf || valid !== 1'b1) begin
                        n_err++;
                        $display("FAIL main_window: count=%h ovf=%b valid=%b, want count=%h ovf=%b valid=1",
                                 cnt_out, ovf, valid, e.cnt, e.ovf);
                    end
                end
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (load_l === 1'b1) begin
                @(negedge clk);
                n_cmp++;
                if (q_long.size() == 0) begin
                    n_err++;
                    $display("FAIL long_unexpected_load: LOAD seen with no expected window");
                end else begin
                    e = q_long.pop_front();
                    if (cnt_out_l !== e.cnt || ovf_l !== e.ovf || valid_l !== 1'b1) begin
                        n_err++;
                        $display("FAIL long_window: count=%h ovf=%b valid=%b, want count=%h ovf=%b valid=1",
                                 cnt_out_l, ovf_l, valid_l, e.cnt, e.ovf);
                    end
                end
            end
        end
    end

    task automatic drain(input string nm);
        int t = 0;
        while ((q_main.size() != 0 || q_long.size() != 0) && t < 300) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        n_cmp++;
        if (q_main.size() != 0 || q_long.size() != 0) begin
            n_err++;
            $display("FAIL %s_drain: %0d/%0d windows still pending, want 0", nm,
                     q_main.size(), q_long.size());
        end
    endtask

    // Requests a window from IDLE; returns at the negedge inside the first COUNT cycle.
    task automatic start_enable(input string nm);
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (sclr !== 1'b1 || load !== 1'b0) begin
            n_err++;
            $display("FAIL %s_start: sclr=%b load=%b, want sclr=1 load=0", nm, sclr, load);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; en_l = 1'b0; pulse = 2'b00; pulse_l = 2'b00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            pulse = ~pulse;
        end
        n_cmp++;
        if (inc !== 2'b00 || sclr !== 1'b0 || load !== 1'b0) begin
            n_err++;
            $display("FAIL reset_strobes: inc=%b sclr=%b load=%b, want 0", inc, sclr, load);
        end
        n_cmp++;
        if (cnt_out !== 8'h00 || valid !== 1'b0 || ovf !== 2'b00) begin
            n_err++;
            $display("FAIL reset_results: count=%h valid=%b ovf=%b, want 0", cnt_out, valid, ovf);
        end
        n_cmp++;
        if (cnt_out_l !== 8'h00 || valid_l !== 1'b0 || load_l !== 1'b0) begin
            n_err++;
            $display("FAIL reset_long: count=%h valid=%b load=%b, want 0", cnt_out_l, valid_l,
                     load_l);
        end
        q_main.push_back('{cnt: 8'h00, ovf: 2'b00});
        pulse = 2'b00;
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (sclr !== 1'b1) begin
            n_err++;
            $display("FAIL reset_first_sclr: sclr=%b, want 1", sclr);
        end
        en = 1'b0;
        drain("reset");
    endtask

    task automatic test_basic();
        q_main.push_back('{cnt: {4'd3, 4'd5}, ovf: 2'b00});
        start_enable("basic");
        for (int i = 0; i < 5; i++) begin
            pulse = {(i < 3), 1'b1};
            @(negedge clk);
            @(negedge clk);
            if (i == 0) begin
                n_cmp++;
                if (inc !== 2'b00) begin
                    n_err++;
                    $display("FAIL basic_inc_early: inc=%b, want 00", inc);
                end
            end
            pulse = 2'b00;
            @(negedge clk);
            if (i == 0) begin
                n_cmp++;
                if (inc !== 2'b11) begin
                    n_err++;
                    $display("FAIL basic_inc_latency: inc=%b, want 11", inc);
                end
            end
        end
        n_cmp++;
        if (load !== 1'b1 || inc !== 2'b01) begin
            n_err++;
            $display("FAIL basic_load_cycle: load=%b inc=%b, want load=1 inc=01", load, inc);
        end
        en = 1'b0;
        drain("basic");
    endtask

    task automatic test_boundary();
        q_main.push_back('{cnt: {4'd0, 4'd1}, ovf: 2'b00});
        q_main.push_back('{cnt: {4'd1, 4'd0}, ovf: 2'b00});
        start_enable("boundary");
        repeat (12) @(negedge clk);
        pulse = 2'b01;
        @(negedge clk);
        pulse = 2'b10;
        @(negedge clk);
        pulse = 2'b00;
        @(negedge clk);
        n_cmp++;
        if (load !== 1'b1 || inc !== 2'b01) begin
            n_err++;
            $display("FAIL boundary_load_inc: load=%b inc=%b, want load=1 inc=01", load, inc);
        end
        @(negedge clk);
        n_cmp++;
        if (load !== 1'b0 || sclr !== 1'b0 || inc !== 2'b10) begin
            n_err++;
            $display("FAIL boundary_next_inc: load=%b sclr=%b inc=%b, want 0 0 10", load, sclr,
                     inc);
        end
        en = 1'b0;
        drain("boundary");
    endtask

    task automatic test_mid_reset();
        int loads = 0;
        start_enable("midrst");
        pulse = 2'b11;
        @(negedge clk);
        pulse = 2'b00;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (cnt_out !== 8'h00 || valid !== 1'b0 || ovf !== 2'b00 || load !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_clear: count=%h valid=%b ovf=%b load=%b, want 0", cnt_out,
                     valid, ovf, load);
        end
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (load === 1'b1) loads++;
        end
        n_cmp++;
        if (loads != 0) begin
            n_err++;
            $display("FAIL midrst_no_load: %0d LOAD pulses, want 0", loads);
        end
    endtask

    task automatic test_disable();
        q_main.push_back('{cnt: {4'd1, 4'd2}, ovf: 2'b00});
        start_enable("disable");
        pulse = 2'b11;
        @(negedge clk);
        @(negedge clk);
        pulse = 2'b00;
        @(negedge clk);
        @(negedge clk);
        pulse = 2'b01;
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        pulse = 2'b00;
        drain("disable");
        pulse = 2'b10;
        @(negedge clk);
        pulse = 2'b00;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (inc !== 2'b10 || load !== 1'b0 || cnt_out !== {4'd1, 4'd2}) begin
            n_err++;
            $display("FAIL disable_idle: inc=%b load=%b count=%h, want inc=10 load=0 count=12",
                     inc, load, cnt_out);
        end
        q_main.push_back('{cnt: 8'h00, ovf: 2'b00});
        start_enable("reenable");
        en = 1'b0;
        drain("reenable");
    endtask

    task automatic test_overflow();
`ifdef PULSE_CNT_SATURATE_EN
        q_long.push_back('{cnt: {4'd0, 4'd15}, ovf: 2'b01});
`else
        q_long.push_back('{cnt: {4'd0, 4'd4}, ovf: 2'b01});
`endif
        q_long.push_back('{cnt: {4'd0, 4'd3}, ovf: 2'b00});
        @(negedge clk);
        en_l = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (sclr_l !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_start: sclr=%b, want 1", sclr_l);
        end
        for (int k = 0; k < 48; k++) begin
            pulse_l = {1'b0, (k < 40) && (k % 2 == 0)};
            @(negedge clk);
        end
        for (int k = 0; k < 12; k++) begin
            pulse_l = {1'b0, (k % 4) < 2};
            if (k == 2) en_l = 1'b0;
            @(negedge clk);
        end
        pulse_l = 2'b00;
        drain("ovf");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundary();
        test_mid_reset();
        test_disable();
        test_overflow();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
